// File: rtl/mat_switch_pkg.sv
// Shared types and default sizing for the buffered matrix-core switch.
// Optional stall counters are enabled by defining MAT_SWITCH_STALL_CNT_EN.
package mat_switch_pkg;

  localparam int DEFAULT_NUM_CORES = 32'd4;
  localparam int DEFAULT_WIDTH     = 32'd16;
  localparam int DEFAULT_DATA_BITS = 32'd32;
  localparam int DEFAULT_DEPTH     = 32'd2;

  typedef logic [DEFAULT_DATA_BITS-1:0] word_t;
  typedef word_t [DEFAULT_WIDTH-1:0]    vec_t;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int idx_bits(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/mat_switch_fifo.sv
// Single-writer / single-reader FIFO for one (source, destination) pair.
// Full/empty come from the registered count, so there is no write-through.
module mat_switch_fifo
  import mat_switch_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_WIDTH * DEFAULT_DATA_BITS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = idx_bits(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/mat_switch_buffered.sv
// Point-to-point switch: one FIFO per ordered (source, destination) core pair.
// Define MAT_SWITCH_STALL_CNT_EN to add per-source saturating stall counters.
module mat_switch_buffered
  import mat_switch_pkg::*;
#(
  parameter int   NUM_CORES = DEFAULT_NUM_CORES,
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter int   DATA_BITS = DEFAULT_DATA_BITS,
  parameter int   DEPTH     = DEFAULT_DEPTH,
  localparam int  ADDR_BITS = idx_bits(NUM_CORES)
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [NUM_CORES-1:0]                        send_ready,
  input  logic [NUM_CORES-1:0][ADDR_BITS-1:0]         send_core_idx,
  input  logic [NUM_CORES-1:0][WIDTH-1:0][DATA_BITS-1:0] send_data,
  output logic [NUM_CORES-1:0]                        send_ok,
  input  logic [NUM_CORES-1:0]                        recv_request,
  input  logic [NUM_CORES-1:0][ADDR_BITS-1:0]         recv_core_idx,
  output logic [NUM_CORES-1:0]                        recv_ready,
  output logic [NUM_CORES-1:0][WIDTH-1:0][DATA_BITS-1:0] recv_data
`ifdef MAT_SWITCH_STALL_CNT_EN
  ,
  output logic [NUM_CORES-1:0][31:0]                  stall_count
`endif
);

  localparam int VEC_BITS = WIDTH * DATA_BITS;

  logic                full_s  [NUM_CORES][NUM_CORES];
  logic                empty_s [NUM_CORES][NUM_CORES];
  logic [VEC_BITS-1:0] head_s  [NUM_CORES][NUM_CORES];
  logic                push_s  [NUM_CORES][NUM_CORES];
  logic                pop_s   [NUM_CORES][NUM_CORES];

  logic [NUM_CORES-1:0] send_full_s;
  logic [NUM_CORES-1:0] recv_empty_s;
  logic [VEC_BITS-1:0]  recv_head_s [NUM_CORES];
  logic [NUM_CORES-1:0] accept_send_s;
  logic [NUM_CORES-1:0] accept_recv_s;

  logic [NUM_CORES-1:0]                           send_ok_r;
  logic [NUM_CORES-1:0]                           recv_ready_r;
  logic [NUM_CORES-1:0][WIDTH-1:0][DATA_BITS-1:0] recv_data_r;

  // Select each core's target FIFO status; out-of-range indices never accept.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      send_full_s[c]  = 1'b1;
      recv_empty_s[c] = 1'b1;
      recv_head_s[c]  = {VEC_BITS{1'b0}};
      if (int'(send_core_idx[c]) < NUM_CORES) begin
        send_full_s[c] = full_s[c][send_core_idx[c]];
      end else begin
        send_full_s[c] = 1'b1;
      end
      if (int'(recv_core_idx[c]) < NUM_CORES) begin
        recv_empty_s[c] = empty_s[recv_core_idx[c]][c];
        recv_head_s[c]  = head_s[recv_core_idx[c]][c];
      end else begin
        recv_empty_s[c] = 1'b1;
        recv_head_s[c]  = {VEC_BITS{1'b0}};
      end
    end
  end

  // A pending acknowledge masks the request so a held request enqueues once.
  always_comb begin
    accept_send_s = send_ready & ~send_ok_r & ~send_full_s;
    accept_recv_s = recv_request & ~recv_ready_r & ~recv_empty_s;
  end

  // Demultiplex accepted handshakes onto the per-pair push/pop strobes.
  always_comb begin
    for (int s = 0; s < NUM_CORES; s++) begin
      for (int d = 0; d < NUM_CORES; d++) begin
        push_s[s][d] = accept_send_s[s] & (send_core_idx[s] == ADDR_BITS'(d));
        pop_s[s][d]  = accept_recv_s[d] & (recv_core_idx[d] == ADDR_BITS'(s));
      end
    end
  end

  for (genvar s = 0; s < NUM_CORES; s++) begin : gen_src
    for (genvar d = 0; d < NUM_CORES; d++) begin : gen_dst
      mat_switch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (VEC_BITS)
      ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s[s][d]),
        .pop   (pop_s[s][d]),
        .din   (send_data[s]),
        .full  (full_s[s][d]),
        .empty (empty_s[s][d]),
        .head  (head_s[s][d])
      );
    end
  end

  // Acknowledge pulses and registered receive data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      send_ok_r    <= {NUM_CORES{1'b0}};
      recv_ready_r <= {NUM_CORES{1'b0}};
      recv_data_r  <= {(NUM_CORES*VEC_BITS){1'b0}};
    end else begin
      send_ok_r    <= accept_send_s;
      recv_ready_r <= accept_recv_s;
      for (int d = 0; d < NUM_CORES; d++) begin
        if (accept_recv_s[d]) recv_data_r[d] <= recv_head_s[d];
      end
    end
  end

  assign send_ok    = send_ok_r;
  assign recv_ready = recv_ready_r;
  assign recv_data  = recv_data_r;

`ifdef MAT_SWITCH_STALL_CNT_EN
  logic [NUM_CORES-1:0]       stall_s;
  logic [NUM_CORES-1:0][31:0] stall_r;

  assign stall_s = send_ready & ~send_ok_r & send_full_s;

  // Saturating count of cycles each source spends blocked on a full FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_r <= {(NUM_CORES*32){1'b0}};
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (stall_s[c] && (stall_r[c] != 32'hFFFF_FFFF)) stall_r[c] <= stall_r[c] + 32'd1;
      end
    end
  end

  assign stall_count = stall_r;
`endif

endmodule

// File: tb/tb_mat_switch_buffered.sv
// Directed self-checking bench for mat_switch_buffered at default sizing.
// Stall counter checks are included when MAT_SWITCH_STALL_CNT_EN is defined.
module tb_mat_switch_buffered;
  import mat_switch_pkg::*;

  logic                 clock;
  logic                 reset;
  logic [3:0]           send_ready;
  logic [3:0][1:0]      send_core_idx;
  logic [3:0][15:0][31:0] send_data;
  logic [3:0]           send_ok;
  logic [3:0]           recv_request;
  logic [3:0][1:0]      recv_core_idx;
  logic [3:0]           recv_ready;
  logic [3:0][15:0][31:0] recv_data;
`ifdef MAT_SWITCH_STALL_CNT_EN
  logic [3:0][31:0]     stall_count;
`endif

  int tests_run;
  int tests_failed;

  mat_switch_buffered dut (
    .clock         (clock),
    .reset         (reset),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .send_data     (send_data),
    .send_ok       (send_ok),
    .recv_request  (recv_request),
    .recv_core_idx (recv_core_idx),
    .recv_ready    (recv_ready),
    .recv_data     (recv_data)
`ifdef MAT_SWITCH_STALL_CNT_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk_vec(input int base);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = 32'(base + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ok(input string name, input logic [3:0] exp);
    tests_run++;
    if (send_ok !== exp) begin
      tests_failed++;
      $display("FAIL %s: send_ok got %b expected %b", name, send_ok, exp);
    end
  endtask

  task automatic chk_rr(input string name, input logic [3:0] exp);
    tests_run++;
    if (recv_ready !== exp) begin
      tests_failed++;
      $display("FAIL %s: recv_ready got %b expected %b", name, recv_ready, exp);
    end
  endtask

  task automatic chk_rd(input string name, input int core, input vec_t exp);
    tests_run++;
    if (recv_data[core] !== exp) begin
      tests_failed++;
      $display("FAIL %s: recv_data[%0d] got %h expected %h", name, core, recv_data[core], exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    send_ready = 4'b0; send_core_idx = '0; send_data = '0;
    recv_request = 4'b0; recv_core_idx = '0;
    #3;
    chk_ok("reset_send_ok", 4'b0000);
    chk_rr("reset_recv_ready", 4'b0000);
    tests_run++;
    if (recv_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_recv_data: got %h expected 0", recv_data);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk_ok("post_reset_idle", 4'b0000);
  endtask

  task automatic test_basic();
    send_core_idx[0] = 2'd2; send_data[0] = mk_vec(0); send_ready[0] = 1'b1;
    tick(); chk_ok("basic_send_ok", 4'b0001);
    send_ready[0] = 1'b0;
    tick(); chk_ok("basic_send_ok_drop", 4'b0000);
    recv_core_idx[2] = 2'd0; recv_request[2] = 1'b1;
    tick(); chk_rr("basic_recv_ready", 4'b0100); chk_rd("basic_recv_data", 2, mk_vec(0));
    recv_request[2] = 1'b0;
    tick(); chk_rr("basic_recv_pulse", 4'b0000); chk_rd("basic_recv_hold", 2, mk_vec(0));
  endtask

  task automatic test_full();
    send_core_idx[1] = 2'd3; send_data[1] = mk_vec(100); send_ready[1] = 1'b1;
    tick(); chk_ok("full_a_ok", 4'b0010);
    send_data[1] = mk_vec(200);
    tick(); chk_ok("full_ok_masked", 4'b0000);
    tick(); chk_ok("full_b_ok", 4'b0010);
    send_data[1] = mk_vec(300);
    tick(); chk_ok("full_c_masked", 4'b0000);
    tick(); chk_ok("full_c_stall1", 4'b0000);
    tick(); chk_ok("full_c_stall2", 4'b0000);
`ifdef MAT_SWITCH_STALL_CNT_EN
    tests_run++;
    if (stall_count[1] !== 32'd2) begin
      tests_failed++;
      $display("FAIL full_stall_count: got %0d expected 2", stall_count[1]);
    end
`endif
    // Full FIFO: pop wins, push stays blocked this edge.
    recv_core_idx[3] = 2'd1; recv_request[3] = 1'b1;
    tick(); chk_rr("full_pop_a", 4'b1000); chk_rd("full_data_a", 3, mk_vec(100));
    chk_ok("full_push_blocked", 4'b0000);
    tick(); chk_ok("full_c_ok", 4'b0010); chk_rr("full_rr_masked", 4'b0000);
    send_ready[1] = 1'b0;
    tick(); chk_rr("full_pop_b", 4'b1000); chk_rd("full_data_b", 3, mk_vec(200));
    tick(); chk_rr("full_rr_masked2", 4'b0000);
    tick(); chk_rr("full_pop_c", 4'b1000); chk_rd("full_data_c", 3, mk_vec(300));
    recv_request[3] = 1'b0;
`ifdef MAT_SWITCH_STALL_CNT_EN
    tests_run++;
    if (stall_count[1] !== 32'd3) begin
      tests_failed++;
      $display("FAIL full_stall_final: got %0d expected 3", stall_count[1]);
    end
`endif
    tick();
  endtask

  task automatic test_push_pop_count1();
    send_core_idx[0] = 2'd1; send_data[0] = mk_vec(400); send_ready[0] = 1'b1;
    tick(); chk_ok("pp_x_ok", 4'b0001);
    send_ready[0] = 1'b0;
    tick();
    send_data[0] = mk_vec(500); send_ready[0] = 1'b1;
    recv_core_idx[1] = 2'd0; recv_request[1] = 1'b1;
    tick(); chk_ok("pp_y_ok", 4'b0001); chk_rr("pp_pop_x", 4'b0010);
    chk_rd("pp_data_x", 1, mk_vec(400));
    send_ready[0] = 1'b0; recv_request[1] = 1'b0;
    tick();
    recv_request[1] = 1'b1;
    tick(); chk_rr("pp_pop_y", 4'b0010); chk_rd("pp_data_y", 1, mk_vec(500));
    recv_request[1] = 1'b0;
    tick();
    recv_request[1] = 1'b1;
    tick(); chk_rr("pp_now_empty", 4'b0000);
    recv_request[1] = 1'b0;
    tick();
  endtask

  task automatic test_no_write_through();
    send_core_idx[1] = 2'd2; send_data[1] = mk_vec(600); send_ready[1] = 1'b1;
    recv_core_idx[2] = 2'd1; recv_request[2] = 1'b1;
    tick(); chk_ok("nwt_send_ok", 4'b0010); chk_rr("nwt_no_bypass", 4'b0000);
    send_ready[1] = 1'b0;
    tick(); chk_rr("nwt_recv_later", 4'b0100); chk_rd("nwt_data", 2, mk_vec(600));
    recv_request[2] = 1'b0;
    tick();
  endtask

  task automatic test_concurrent();
    for (int c = 0; c < 4; c++) send_data[c] = mk_vec(1000 + 100 * c);
    send_core_idx[0] = 2'd1; send_core_idx[1] = 2'd2;
    send_core_idx[2] = 2'd3; send_core_idx[3] = 2'd3;
    send_ready = 4'b1111;
    tick(); chk_ok("conc_all_ok", 4'b1111);
    send_ready = 4'b0000;
    recv_core_idx[1] = 2'd0; recv_core_idx[2] = 2'd1; recv_core_idx[3] = 2'd3;
    recv_request = 4'b1110;
    tick(); chk_rr("conc_recv", 4'b1110);
    chk_rd("conc_data1", 1, mk_vec(1000));
    chk_rd("conc_data2", 2, mk_vec(1100));
    chk_rd("conc_self3", 3, mk_vec(1300));
    recv_request = 4'b0000;
    tick();
    recv_core_idx[3] = 2'd2; recv_request[3] = 1'b1;
    tick(); chk_rr("conc_recv3b", 4'b1000); chk_rd("conc_data3b", 3, mk_vec(1200));
    recv_request[3] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    send_core_idx[2] = 2'd1; send_data[2] = mk_vec(2000); send_ready[2] = 1'b1;
    tick(); chk_ok("rm_v1_ok", 4'b0100);
    send_data[2] = mk_vec(2100);
    tick();
    tick(); chk_ok("rm_v2_ok", 4'b0100);
    send_data[2] = mk_vec(2200);
    tick();
    tick(); chk_ok("rm_stalled", 4'b0000);
    reset = 1'b0;
    #1;
    chk_ok("rm_async_ok", 4'b0000);
    chk_rr("rm_async_rr", 4'b0000);
    tests_run++;
    if (recv_data !== '0) begin
      tests_failed++;
      $display("FAIL rm_async_data: got %h expected 0", recv_data);
    end
`ifdef MAT_SWITCH_STALL_CNT_EN
    tests_run++;
    if (stall_count !== '0) begin
      tests_failed++;
      $display("FAIL rm_stall_clear: got %h expected 0", stall_count);
    end
`endif
    reset = 1'b1;
    tick(); chk_ok("rm_reaccept", 4'b0100);
    send_ready[2] = 1'b0;
    tick();
    recv_core_idx[1] = 2'd2; recv_request[1] = 1'b1;
    tick(); chk_rr("rm_pop_v3", 4'b0010); chk_rd("rm_data_v3", 1, mk_vec(2200));
    tick(); chk_rr("rm_masked", 4'b0000);
    tick(); chk_rr("rm_empty", 4'b0000);
    recv_request[1] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_full();
    test_push_pop_count1();
    test_no_write_through();
    test_concurrent();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
